multicycle_control: RTL and testbench

//  Moore FSM control unit for the multi-cycle MIPS datapath; next generation of the single-cycle opcode decoder.

---
 rtl/mc_ctrl_pkg.sv | 70 +++++++
 rtl/mc_wait_timer.sv | 46 ++++
 rtl/multicycle_control.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Package     : mc_ctrl_pkg
// Description : Shared types and encodings for the multi-cycle MIPS control
//               unit: FSM state enum, opcode constants, ALUOp / PCSource /
//               ALUSrcB codes and error codes.
// Config      : MC_CTRL_ILLEGAL_TRAP_EN (used by multicycle_control)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

  // FSM states; the encoding is visible on state_dbg
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_R_EXEC   = 4'd3,
    S_R_WB     = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_BEQ      = 4'd9,
    S_BNE      = 4'd10,
    S_IMM_EXEC = 4'd11,
    S_IMM_WB   = 4'd12,
    S_JUMP     = 4'd13,
    S_HALT     = 4'd14
  } state_e;

  // Opcode field values (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU control classes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_XOR   = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Error codes reported in HALT
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  // States that wait on the memory ready handshake
  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// ============================================================================
// Module      : mc_wait_timer
// Description : Memory wait-cycle counter. Counts not-ready cycles while
//               enabled and flags a timeout on the MEM_TIMEOUT-th one, unless
//               mem_ready arrives in that same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  input  logic mem_ready_i,
  output logic timeout_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter register, cleared asynchronously on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Clear on state change, otherwise count saturating not-ready cycles
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !mem_ready_i && (cnt_q != CNT_W'(MEM_TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign timeout_o = enable_i && !mem_ready_i && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Moore FSM control unit for the multi-cycle MIPS datapath.
//               Sequences fetch/decode/execute/memory/writeback, stalls on
//               mem_ready and halts on memory timeout.
// Config      : MC_CTRL_ILLEGAL_TRAP_EN - unknown opcode traps to HALT with
//               err_code=10; otherwise it is executed as a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                IRWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic                SignZero,
  output logic                BranchNE,
  output logic [1:0]          PCSource,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                halted,
  output logic [1:0]          err_code,
  output logic [3:0]          state_dbg
);

  state_e     state_q, state_d;
  logic       is_sw_q, is_sw_d;
  logic [1:0] err_q, err_d;
  logic       timeout;

  mc_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (state_d != state_q),
    .enable_i    (is_wait_state(state_q)),
    .mem_ready_i (mem_ready),
    .timeout_o   (timeout)
  );

  // State, latched load/store flavour and error code registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      is_sw_q <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic, including opcode dispatch and timeout handling
  always_comb begin
    state_d = state_q;
    is_sw_d = is_sw_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        is_sw_d = (Opcode == OPCODE_W'(OP_SW));
        if (Opcode == OPCODE_W'(OP_RTYPE))                                   state_d = S_R_EXEC;
        else if ((Opcode == OPCODE_W'(OP_LW)) || (Opcode == OPCODE_W'(OP_SW))) state_d = S_MEM_ADDR;
        else if (Opcode == OPCODE_W'(OP_BEQ))                                state_d = S_BEQ;
        else if (Opcode == OPCODE_W'(OP_BNE))                                state_d = S_BNE;
        else if (Opcode == OPCODE_W'(OP_XORI))                               state_d = S_IMM_EXEC;
        else if (Opcode == OPCODE_W'(OP_J))                                  state_d = S_JUMP;
        else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_R_EXEC:   state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_MEM_ADDR: state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_MEM_WB:   state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_BNE:      state_d = S_FETCH;
      S_IMM_EXEC: state_d = S_IMM_WB;
      S_IMM_WB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
  end

  // Moore output decode; only FETCH looks at mem_ready to gate PC/IR writes
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    SignZero    = 1'b0;
    BranchNE    = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_W'(ALUOP_ADD);
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE:   ALUSrcB = SRCB_IMM_SH2;
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_W'(ALUOP_FUNCT);
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_BEQ, S_BNE: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_W'(ALUOP_SUB);
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        BranchNE    = (state_q == S_BNE);
      end
      S_IMM_EXEC: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_IMM;
        ALUOp    = ALUOP_W'(ALUOP_XOR);
        SignZero = 1'b1;
      end
      S_IMM_WB:   RegWrite = 1'b1;
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  assign halted    = (state_q == S_HALT);
  assign err_code  = err_q;
  assign state_dbg = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module      : tb_multicycle_control
// Description : Scoreboard bench for multicycle_control. The stimulus process
//               drives Opcode/mem_ready each cycle and queues the expected
//               state and control vector; a monitor pops and compares on the
//               falling edge.
// Config      : MC_CTRL_ILLEGAL_TRAP_EN selects the illegal-opcode outcome
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, R_EXEC = 4'd3,
                         R_WB = 4'd4, MEM_ADDR = 4'd5, MEM_RD = 4'd6, MEM_WR = 4'd7,
                         MEM_WB = 4'd8, BEQ = 4'd9, BNE = 4'd10, IMM_EXEC = 4'd11,
                         IMM_WB = 4'd12, JUMP = 4'd13, HALT = 4'd14;

  typedef struct packed {
    logic pcw, pcwc, iord, irw, mr, mw, m2r, rdst, rw, asa, sz, bne;
    logic [1:0] pcs, asb, aop;
    logic       hlt;
    logic [1:0] err;
    logic [3:0] st;
  } obs_t;

  typedef struct {
    int   id;
    obs_t exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Opcode = 6'd0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg;
  logic       RegDst, RegWrite, ALUSrcA, SignZero, BranchNE, halted;
  logic [1:0] PCSource, ALUSrcB, ALUOp, err_code;
  logic [3:0] state_dbg;

  obs_t       obs;
  sb_t        sb_q[$];
  int         total = 0;
  int         bad = 0;
  int         step_id = 0;
  logic [1:0] exp_err = 2'b00;

  multicycle_control #(
    .OPCODE_W    (6),
    .ALUOP_W     (2),
    .MEM_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Opcode      (Opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .IRWrite     (IRWrite),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .SignZero    (SignZero),
    .BranchNE    (BranchNE),
    .PCSource    (PCSource),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .halted      (halted),
    .err_code    (err_code),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, SignZero, BranchNE, PCSource, ALUSrcB,
                ALUOp, halted, err_code, state_dbg};

  // Expected outputs for one state, written out from the control table
  function automatic obs_t exp_ctrl(logic [3:0] st, logic rdy, logic [1:0] err);
    obs_t e;
    e = '0;
    e.st = st;
    case (st)
      FETCH:    begin e.mr = 1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy; end
      DECODE:   e.asb = 2'b11;
      R_EXEC:   begin e.asa = 1; e.aop = 2'b10; end
      R_WB:     begin e.rdst = 1; e.rw = 1; end
      MEM_ADDR: begin e.asa = 1; e.asb = 2'b10; end
      MEM_RD:   begin e.mr = 1; e.iord = 1; end
      MEM_WR:   begin e.mw = 1; e.iord = 1; end
      MEM_WB:   begin e.m2r = 1; e.rw = 1; end
      BEQ:      begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; end
      BNE:      begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; e.bne = 1; end
      IMM_EXEC: begin e.asa = 1; e.asb = 2'b10; e.aop = 2'b11; e.sz = 1; end
      IMM_WB:   e.rw = 1;
      JUMP:     begin e.pcw = 1; e.pcs = 2'b10; end
      HALT:     begin e.hlt = 1; e.err = err; end
      default:  ;
    endcase
    return e;
  endfunction

  task automatic push_exp(input logic [3:0] st, input logic rdy);
    sb_t s;
    step_id++;
    s.id  = step_id;
    s.exp = exp_ctrl(st, rdy, exp_err);
    sb_q.push_back(s);
  endtask

  // One clock cycle: drive inputs, queue the expected observation, advance
  task automatic step(input logic [5:0] op, input logic rdy, input logic [3:0] st);
    Opcode    = op;
    mem_ready = rdy;
    push_exp(st, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_err = 2'b00;
  endtask

  // Monitor: compare the DUT against the oldest expectation every falling edge
  always @(negedge clk) begin
    sb_t s;
    if (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      total++;
      if (obs !== s.exp) begin
        bad++;
        $display("FAIL step%0d: got state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                 s.id, obs.st, obs, s.exp.st, s.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // R-type: reset state then FETCH, DECODE, R_EXEC, R_WB
    step(6'b000000, 1, IDLE);
    step(6'b000000, 1, FETCH);
    step(6'b000000, 1, DECODE);
    step(6'b000000, 1, R_EXEC);
    step(6'b000000, 1, R_WB);

    // lw with three not-ready cycles in MEM_RD
    step(6'b000000, 1, FETCH);
    step(6'b100011, 1, DECODE);
    step(6'b000000, 1, MEM_ADDR);
    step(6'b000000, 0, MEM_RD);
    step(6'b000000, 0, MEM_RD);
    step(6'b000000, 0, MEM_RD);
    step(6'b000000, 1, MEM_RD);
    step(6'b000000, 1, MEM_WB);

    // sw, zero wait
    step(6'b000000, 1, FETCH);
    step(6'b101011, 1, DECODE);
    step(6'b000000, 1, MEM_ADDR);
    step(6'b000000, 1, MEM_WR);

    // beq then bne
    step(6'b000000, 1, FETCH);
    step(6'b000100, 1, DECODE);
    step(6'b000000, 1, BEQ);
    step(6'b000000, 1, FETCH);
    step(6'b000101, 1, DECODE);
    step(6'b000000, 1, BNE);

    // xori
    step(6'b000000, 1, FETCH);
    step(6'b001110, 1, DECODE);
    step(6'b000000, 1, IMM_EXEC);
    step(6'b000000, 1, IMM_WB);

    // j
    step(6'b000000, 1, FETCH);
    step(6'b000010, 1, DECODE);
    step(6'b000000, 1, JUMP);

    // Fetch: 15 waits, ready on the 16th -> no halt
    for (int i = 0; i < 15; i++) step(6'b000000, 0, FETCH);
    step(6'b000000, 1, FETCH);
    step(6'b000010, 1, DECODE);
    step(6'b000000, 1, JUMP);

    // Fetch: 16 waits -> HALT with timeout code, sticky
    for (int i = 0; i < 16; i++) step(6'b000000, 0, FETCH);
    exp_err = 2'b01;
    step(6'b000000, 1, HALT);
    step(6'b000000, 1, HALT);
    step(6'b000000, 1, HALT);

    // Async reset in the middle of a stalled store
    do_reset();
    step(6'b000000, 1, IDLE);
    step(6'b000000, 1, FETCH);
    step(6'b101011, 1, DECODE);
    step(6'b000000, 1, MEM_ADDR);
    step(6'b000000, 0, MEM_WR);
    mem_ready = 1'b0;
    #1;
    reset = 1'b1;
    push_exp(IDLE, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Illegal opcode
    step(6'b000000, 1, IDLE);
    step(6'b000000, 1, FETCH);
    step(6'b111111, 1, DECODE);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    exp_err = 2'b10;
    step(6'b000000, 1, HALT);
    step(6'b000000, 1, HALT);
`else
    step(6'b000000, 1, FETCH);
    step(6'b000000, 1, DECODE);
    step(6'b000000, 1, R_EXEC);
`endif

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
